// File: rtl/range_stream_tx_if.sv
// Sample-load / burst-playout bundle between a loader and range_stream_tx.
// The loader drives the master side; the transmitter implements the slave side.
interface range_stream_tx_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    logic [WIDTH-1:0]           wr_data;
    logic                       wr_en;
    logic                       start;
    logic                       full;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       busy;
    logic                       done;
    logic [WIDTH-1:0]           data_out;
    logic                       go;
    logic                       finish;
    logic                       err;

    modport master (
        output wr_data, wr_en, start,
        input  full, count, busy, done, data_out, go, finish, err
    );

    modport slave (
        input  wr_data, wr_en, start,
        output full, count, busy, done, data_out, go, finish, err
    );
endinterface

// File: rtl/range_stream_tx.sv
// Buffers a burst of samples in a circular FIFO, then plays it out as
// data_out/go/finish for a range_finder-style receiver.
module range_stream_tx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    range_stream_tx_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             first_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             go_reg;
    logic             finish_reg;
    logic             err_reg;
    logic [WIDTH-1:0] data_reg;

    logic full;
    logic wr_ok;
    logic pop;

    assign full  = (count_reg == DEPTH_C);
    // Loading is only allowed outside the burst; SEND owns the FIFO.
    assign wr_ok = (state_reg != SEND) && bus.wr_en && !full;
    assign pop   = (state_reg == SEND);

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            first_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            go_reg     <= 1'b0;
            finish_reg <= 1'b0;
            err_reg    <= 1'b0;
            data_reg   <= '0;
        end else begin
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            go_reg     <= 1'b0;
            finish_reg <= 1'b0;
            err_reg    <= 1'b0;

            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                count_reg  <= count_reg + ONE_C;
            end else if (pop) begin
                count_reg  <= count_reg - ONE_C;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.wr_en && full) begin
                        err_reg <= 1'b1;
                    end
                    if (bus.start) begin
                        // A write accepted this same cycle counts toward the burst.
                        if (count_reg != '0 || wr_ok) begin
                            state_reg <= SEND;
                            first_reg <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    data_reg   <= mem[rd_ptr_reg];
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    go_reg     <= first_reg;
                    first_reg  <= 1'b0;
                    busy_reg   <= 1'b1;
                    if (bus.wr_en) begin
                        err_reg <= 1'b1;
                    end
                    if (count_reg == ONE_C) begin
                        finish_reg <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                    if (bus.wr_en && full) begin
                        err_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.count    = count_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.data_out = data_reg;
    assign bus.go       = go_reg;
    assign bus.finish   = finish_reg;
    assign bus.err      = err_reg;
endmodule

// File: tb/tb_range_stream_tx.sv
// Directed bench for range_stream_tx: loads bursts, plays them out and checks
// markers, counts, error pulses, reset abort and FIFO pointer wrap.
module tb_range_stream_tx;
    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [7:0] exp_s [8];
    logic [7:0] last_range;

    range_stream_tx_if #(.WIDTH(8), .DEPTH(8)) bus ();

    range_stream_tx #(.WIDTH(8), .DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        bus.wr_en   = 1'b1;
        bus.wr_data = v;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) push(exp_s[i]);
    endtask

    // Raise start for one edge; the first sample must not yet be visible.
    task automatic kick();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("go_latency", {31'd0, bus.go}, 32'd0);
    endtask

    // Expect exp_s[0..n-1] on consecutive cycles, then a single done pulse.
    task automatic burst(input string tag, input int n);
        logic [7:0] mx;
        logic [7:0] mn;
        mx = 8'h00;
        mn = 8'hFF;
        for (int i = 0; i < n; i++) begin
            step();
            $display("%s sample %0d data=%0h go=%0b finish=%0b count=%0d",
                     tag, i, bus.data_out, bus.go, bus.finish, bus.count);
            chk({tag, "_data"},   {24'd0, bus.data_out}, {24'd0, exp_s[i]});
            chk({tag, "_go"},     {31'd0, bus.go},       {31'd0, (i == 0)});
            chk({tag, "_finish"}, {31'd0, bus.finish},   {31'd0, (i == n - 1)});
            chk({tag, "_busy"},   {31'd0, bus.busy},     32'd1);
            chk({tag, "_count"},  {28'd0, bus.count},    32'(n - 1 - i));
            if (bus.data_out > mx) mx = bus.data_out;
            if (bus.data_out < mn) mn = bus.data_out;
        end
        step();
        chk({tag, "_done"},      {31'd0, bus.done}, 32'd1);
        chk({tag, "_done_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done_fin"},  {31'd0, bus.finish}, 32'd0);
        step();
        chk({tag, "_done_end"},  {31'd0, bus.done}, 32'd0);
        last_range = mx - mn;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        last_range  = 8'h00;
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.start   = 1'b0;
        step();
        step();
        reset = 1'b0;
        $display("reset state data=%0h count=%0d busy=%0b", bus.data_out, bus.count, bus.busy);
        chk("rst_data",   {24'd0, bus.data_out}, 32'd0);
        chk("rst_go",     {31'd0, bus.go},       32'd0);
        chk("rst_finish", {31'd0, bus.finish},   32'd0);
        chk("rst_busy",   {31'd0, bus.busy},     32'd0);
        chk("rst_done",   {31'd0, bus.done},     32'd0);
        chk("rst_err",    {31'd0, bus.err},      32'd0);
        chk("rst_count",  {28'd0, bus.count},    32'd0);
        chk("rst_full",   {31'd0, bus.full},     32'd0);

        // Four-sample burst; receiver range is max-min = 0x80-0x05.
        exp_s[0] = 8'h10; exp_s[1] = 8'h80; exp_s[2] = 8'h05; exp_s[3] = 8'h33;
        load(4);
        chk("b4_count", {28'd0, bus.count}, 32'd4);
        kick();
        burst("b4", 4);
        chk("b4_range", {24'd0, last_range}, 32'h7B);
        chk("b4_hold",  {24'd0, bus.data_out}, 32'h33);

        // Single-sample burst: go and finish together.
        exp_s[0] = 8'h42;
        load(1);
        kick();
        burst("b1", 1);
        chk("b1_count", {28'd0, bus.count}, 32'd0);

        // Overfill: ninth write dropped with one err pulse.
        for (int i = 0; i < 8; i++) exp_s[i] = 8'(i);
        load(8);
        chk("ovf_full",  {31'd0, bus.full},  32'd1);
        chk("ovf_count", {28'd0, bus.count}, 32'd8);
        chk("ovf_noerr", {31'd0, bus.err},   32'd0);
        push(8'h08);
        $display("overflow push err=%0b count=%0d", bus.err, bus.count);
        chk("ovf_err",    {31'd0, bus.err},   32'd1);
        chk("ovf_count2", {28'd0, bus.count}, 32'd8);
        step();
        chk("ovf_err_end", {31'd0, bus.err}, 32'd0);
        kick();
        burst("b8", 8);

        // Start with empty FIFO: rejected.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        $display("empty start err=%0b busy=%0b go=%0b", bus.err, bus.busy, bus.go);
        chk("empty_err",  {31'd0, bus.err},  32'd1);
        chk("empty_busy", {31'd0, bus.busy}, 32'd0);
        step();
        chk("empty_err_end", {31'd0, bus.err},  32'd0);
        chk("empty_go",      {31'd0, bus.go},   32'd0);
        chk("empty_busy2",   {31'd0, bus.busy}, 32'd0);

        // Write during SEND is rejected and never appears later.
        exp_s[0] = 8'h01; exp_s[1] = 8'h02;
        load(2);
        kick();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h99;
        step();
        bus.wr_en   = 1'b0;
        $display("send write data=%0h err=%0b", bus.data_out, bus.err);
        chk("sw_data0", {24'd0, bus.data_out}, 32'h01);
        chk("sw_err",   {31'd0, bus.err},      32'd1);
        step();
        chk("sw_data1", {24'd0, bus.data_out}, 32'h02);
        chk("sw_fin",   {31'd0, bus.finish},   32'd1);
        chk("sw_err_end", {31'd0, bus.err},    32'd0);
        step();
        chk("sw_done",  {31'd0, bus.done},     32'd1);
        step();
        exp_s[0] = 8'h03;
        load(1);
        chk("sw_count", {28'd0, bus.count}, 32'd1);
        kick();
        burst("sw_after", 1);

        // Reset during the second SEND cycle aborts the burst.
        exp_s[0] = 8'hA1; exp_s[1] = 8'hB2; exp_s[2] = 8'hC3;
        load(3);
        kick();
        step();
        chk("abort_first", {24'd0, bus.data_out}, 32'hA1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("abort data=%0h count=%0d finish=%0b", bus.data_out, bus.count, bus.finish);
        chk("abort_data",   {24'd0, bus.data_out}, 32'd0);
        chk("abort_count",  {28'd0, bus.count},    32'd0);
        chk("abort_finish", {31'd0, bus.finish},   32'd0);
        chk("abort_busy",   {31'd0, bus.busy},     32'd0);
        step();
        chk("abort_idle_fin",  {31'd0, bus.finish}, 32'd0);
        chk("abort_idle_done", {31'd0, bus.done},   32'd0);
        exp_s[0] = 8'hD4; exp_s[1] = 8'hE5;
        load(2);
        kick();
        burst("post_rst", 2);

        // Write and start in the same cycle with one sample already buffered.
        push(8'h11);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hAA;
        bus.start   = 1'b1;
        step();
        bus.wr_en   = 1'b0;
        bus.start   = 1'b0;
        exp_s[0] = 8'h11; exp_s[1] = 8'hAA;
        burst("same_cyc", 2);

        // Three back-to-back bursts of six span the pointer wrap.
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 6; i++) exp_s[i] = 8'(8'h20 * (b + 1) + i);
            load(6);
            kick();
            burst($sformatf("wrap%0d", b), 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/range_stream_tx.md
Name: range_stream_tx

Overview:
- Transmit side of the range-finder sample protocol: buffers a burst of samples, then plays them out as data/go/finish so a range_finder-style receiver can compute max-min.
- Sits in my_chip between the io_in load pins and the receiver's data_in/go/finish inputs.
- Also used as the bench driver for the receiver.
- Contains an internal FIFO, a burst state machine and error flagging.

Parameters:
- WIDTH, 8, sample width in bits.
- DEPTH, 8, FIFO capacity in samples; power of two, at least 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_data  input  WIDTH  sample to enqueue.
- wr_en  input  1  enqueue strobe; one sample per cycle.
- start  input  1  begin playing out the buffered burst.
- full  output  1  FIFO holds DEPTH samples.
- count  output  $clog2(DEPTH+1)  number of buffered samples.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after the last sample is sent.
- data_out  output  WIDTH  sample to the receiver (registered).
- go  output  1  first-sample marker (registered).
- finish  output  1  last-sample marker (registered).
- err  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (synchronous, active-high):
  - count=0, full=0, busy=0, done=0, data_out=0, go=0, finish=0, err=0.
  - State=IDLE; FIFO pointers cleared.
  - Applies mid-burst: the burst aborts with no finish, and buffered data is discarded.
- FIFO:
  - Circular buffer of DEPTH entries; pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH; full = (count==DEPTH).
- States: IDLE, SEND, DONE.
- IDLE:
  - wr_en with !full: push wr_data, count+1.
  - wr_en with full: sample dropped, err pulses the next cycle.
  - start with count>=1 (count includes a same-cycle accepted write): go to SEND.
  - start with count==0 (and no accepted write): ignored, err pulses.
- SEND:
  - Each cycle pops one sample into data_out (FIFO order).
  - go=1 only for the first popped sample; finish=1 only for the last one (count==1 at pop).
  - A one-sample burst drives go and finish high in the same cycle.
  - busy=1 on every cycle where go/finish/data_out show a burst sample.
  - After the finish cycle, go to DONE.
- SEND rejections:
  - wr_en is rejected: not stored, err pulses.
  - start is ignored with no err.
- DONE:
  - done=1 for exactly one cycle, busy=0, then return to IDLE.
  - wr_en in DONE is accepted as in IDLE.
  - start in DONE is ignored with no err.
- Latency:
  - start sampled at edge N → first sample with go on the outputs after edge N+1.
  - A burst of k samples occupies k consecutive cycles; done follows in the cycle after finish.
- Idle output values:
  - Outside SEND, go=0 and finish=0.
  - data_out holds the last transmitted sample (0 after reset).
- err is registered: it pulses the cycle after the offending request. Simultaneous violations produce a single pulse.
- count decrements one per SEND cycle and reaches 0 in the finish cycle.

Test Plan:
- Reset, write 0x10, 0x80, 0x05, 0x33, then start → data_out sequence 0x10, 0x80, 0x05, 0x33 on 4 consecutive cycles; go only with 0x10, finish only with 0x33; done next cycle; a downstream range_finder reports 0x7B.
- Write single 0x42, start → one cycle with go=1, finish=1, data_out=0x42; done next cycle; count=0.
- Write 9 samples 0..8 with DEPTH=8 → full=1 after the 8th, 9th dropped, err pulses once; burst sends 0..7 only.
- Start with empty FIFO → err pulse, busy stays 0, go never asserts; wr_en during SEND → err, sample absent from the next burst.
- Load 3 samples, start, assert reset during the 2nd SEND cycle → next cycle all outputs 0, count=0, no finish seen; a new 2-sample burst then works normally.
- Write 0xAA and start in the same IDLE cycle with count=1 (0x11) → burst 0x11, 0xAA with go on 0x11 and finish on 0xAA; wrap check: 3 back-to-back bursts of 6 keep FIFO order across the pointer wrap.
